// File: rtl/data_memory_responder.sv
// Multi-cycle big-endian data-memory responder: one byte/halfword/word access per request,
// completed after WAIT_STATES extra cycles with a one-cycle ready pulse.
module data_memory_responder #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        R,
  input  logic        E,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        se,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            rw_q, rw_d;
  logic            se_q, se_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_out_q, data_out_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [7:0]      mem_q [DEPTH_BYTES];

  logic [AW-1:0]   a_h0, a_h1, a_w0, a_w1, a_w2, a_w3;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_w, load_val;
  logic            misaligned;
  logic            unused_addr_hi;

  // Address bits above the memory size are discarded (address is taken modulo the depth).
  assign unused_addr_hi = ^addr[31:AW];

  assign a_h0 = {addr_q[AW-1:1], 1'b0};
  assign a_h1 = {addr_q[AW-1:1], 1'b1};
  assign a_w0 = {addr_q[AW-1:2], 2'd0};
  assign a_w1 = {addr_q[AW-1:2], 2'd1};
  assign a_w2 = {addr_q[AW-1:2], 2'd2};
  assign a_w3 = {addr_q[AW-1:2], 2'd3};

  assign ld_b = mem_q[addr_q];
  assign ld_h = {mem_q[a_h0], mem_q[a_h1]};
  assign ld_w = {mem_q[a_w0], mem_q[a_w1], mem_q[a_w2], mem_q[a_w3]};

  assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));

  always_comb begin
    unique case (size_q)
      2'b00:   load_val = {{24{se_q & ld_b[7]}}, ld_b};
      2'b01:   load_val = {{16{se_q & ld_h[15]}}, ld_h};
      default: load_val = ld_w;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    rw_d       = rw_q;
    se_d       = se_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (E) begin
          addr_d  = addr[AW-1:0];
          size_d  = size;
          rw_d    = rw;
          se_d    = se;
          wdata_d = data_in;
          wcnt_d  = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (misaligned) begin
            data_out_d = 32'd0;
            err_d      = 1'b1;
          end else begin
            err_d = 1'b0;
            if (rw_q) begin
              mem_we = 1'b1;
            end else begin
              data_out_d = load_val;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      rw_q       <= 1'b0;
      se_q       <= 1'b0;
      wdata_q    <= 32'd0;
      data_out_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      rw_q       <= rw_d;
      se_q       <= se_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Memory is never cleared; reset only suppresses an in-flight store.
  always_ff @(posedge clk) begin
    if (!R && mem_we) begin
      unique case (size_q)
        2'b00: mem_q[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem_q[a_h0] <= wdata_q[15:8];
          mem_q[a_h1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[a_w0] <= wdata_q[31:24];
          mem_q[a_w1] <= wdata_q[23:16];
          mem_q[a_w2] <= wdata_q[15:8];
          mem_q[a_w3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign err      = err_q;
  assign ready    = (state_q == StDone);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed test-plan sequence plus random traffic, all checked
// every cycle against a transaction-level model (byte array + completion time).
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned WS    = 2;

  logic        clk = 1'b0;
  logic        R = 1'b0, E = 1'b0, rw = 1'b0, se = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, data_in = 32'd0;
  logic [31:0] data_out;
  logic        ready, busy, err;

  data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .R(R), .E(E), .rw(rw), .size(size), .se(se), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned nchk = 0, nerr = 0;
  int          cyc = 0;

  // Model: pending request with its completion edge, plus a byte-addressed memory image.
  logic [7:0]  m_mem [DEPTH];
  logic        m_pending = 1'b0, m_ready = 1'b0, m_err = 1'b0;
  logic [31:0] m_dout = 32'd0;
  int          m_done_at = 0;
  logic        q_rw, q_se;
  logic [1:0]  q_size;
  int unsigned q_a;
  logic [31:0] q_data;
  int          ready_edges[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_access();
    int unsigned nbytes;
    logic [31:0] v;
    nbytes = (q_size == 2'b00) ? 1 : (q_size == 2'b01) ? 2 : 4;
    if (q_a % nbytes != 0) begin
      m_dout = 32'd0;
      m_err  = 1'b1;
      return;
    end
    m_err = 1'b0;
    if (q_rw) begin
      for (int i = 0; i < int'(nbytes); i++)
        m_mem[q_a + i] = q_data[8*(nbytes-1-i) +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(nbytes); i++) v = (v << 8) | 32'(m_mem[q_a + i]);
      if (q_se && nbytes == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (q_se && nbytes == 2 && v[15]) v = v | 32'hFFFF_0000;
      m_dout = v;
    end
  endfunction

  // One clock: advance the model at the rising edge, compare the DUT at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (R) begin
      m_pending = 1'b0; m_ready = 1'b0; m_dout = 32'd0; m_err = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0;
    end else if (m_pending) begin
      if (cyc == m_done_at) begin
        model_access();
        m_pending = 1'b0;
        m_ready   = 1'b1;
        ready_edges.push_back(cyc);
      end
    end else if (E) begin
      q_rw = rw; q_se = se; q_size = size; q_a = addr % DEPTH; q_data = data_in;
      m_pending = 1'b1;
      m_done_at = cyc + int'(WS) + 1;
    end
    @(negedge clk);
    check("ready", 32'(ready), 32'(m_ready));
    check("busy", 32'(busy), 32'(m_pending | m_ready));
    check("data_out", data_out, m_dout);
    if (m_ready) check("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_access(input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] d);
    int n;
    E = 1'b1; rw = w; size = sz; se = s; addr = a; data_in = d;
    n = 0;
    while (!m_pending && n < 10) begin step(); n++; end
    E = 1'b0;
    if (!m_pending) check("accept_timeout", 32'(m_pending), 32'd1);
    n = 0;
    while (!(ready || m_ready) && n < 40) begin step(); n++; end
    check("latency", 32'(n), 32'(WS + 1));
  endtask

  initial begin
    int base;
    logic [7:0] v;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = 8'($urandom);
      dut.mem_q[i] = v;
      m_mem[i] = v;
    end
    R = 1'b1;
    step(); step();
    check("rst_data_out", data_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    R = 1'b0;
    step();

    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("store_err", 32'(err), 32'd0);
    step();
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_word", data_out, 32'hDEAD_BEEF);
    step();
    do_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lit_byte_se", data_out, 32'hFFFF_FFAD);
    step();
    do_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lit_byte_ze", data_out, 32'h0000_00AD);
    step();
    do_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lit_half_se", data_out, 32'hFFFF_BEEF);
    step();
    do_access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lit_half_ze", data_out, 32'h0000_DEAD);
    step();
    do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_007F);
    step();
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_merge", data_out, 32'hDEAD_BE7F);
    step();
    do_access(1'b1, 2'b10, 1'b0, 32'h12, 32'h1122_3344);
    check("lit_mis_err", 32'(err), 32'd1);
    check("lit_mis_data", data_out, 32'd0);
    step();
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_mis_nowrite", data_out, 32'hDEAD_BE7F);
    step();

    // Reset in the middle of a store.
    for (int i = 0; i < 4; i++) begin
      dut.mem_q[32 + i] = 8'h00;
      m_mem[32 + i] = 8'h00;
    end
    E = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h20; data_in = 32'hCAFE_F00D;
    step();
    E = 1'b0;
    step();
    R = 1'b1;
    step();
    R = 1'b0;
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 6; i++) step();
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("lit_rst_nowrite", data_out, 32'd0);
    step();

    // E held across ready: the request repeats every WS+3 cycles.
    base = ready_edges.size();
    E = 1'b1; rw = 1'b0; size = 2'b10; se = 1'b0; addr = 32'h10;
    for (int n = 0; n < 60 && ready_edges.size() < base + 2; n++) step();
    E = 1'b0;
    if (ready_edges.size() >= base + 2)
      check("lit_held_gap", 32'(ready_edges[base+1] - ready_edges[base]), 32'(WS + 3));
    else
      check("held_timeout", 32'(ready_edges.size() - base), 32'd2);
    for (int i = 0; i < 6; i++) step();

    // Random traffic, including occasional resets and misaligned requests.
    for (int n = 0; n < 600; n++) begin
      R       = ($urandom_range(0, 39) == 0);
      E       = $urandom_range(0, 1) == 1;
      rw      = $urandom_range(0, 1) == 1;
      size    = 2'($urandom_range(0, 3));
      se      = $urandom_range(0, 1) == 1;
      addr    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      data_in = $urandom;
      step();
    end
    R = 1'b0; E = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
